// File: rtl/fruit_controller_if.sv
// Bundles the fruit controller's game-side signals: candidate stream from the fruit
// generator, head/death info from the snake engine, and the fruit/length/lives results.
interface fruit_controller_if;
  logic       tick;
  logic       game_active;
  logic [9:0] cand_x;
  logic [8:0] cand_y;
  logic [1:0] cand_type;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic       life_lost;
  logic [9:0] fruit_x;
  logic [8:0] fruit_y;
  logic [1:0] fruit_type;
  logic       fruit_visible;
  logic       eat_pulse;
  logic [6:0] snake_len;
  logic [2:0] lives;
  logic       game_over;

  // Environment side: generator, snake engine and renderer.
  modport master (
    output tick, game_active, cand_x, cand_y, cand_type, head_x, head_y, life_lost,
    input  fruit_x, fruit_y, fruit_type, fruit_visible, eat_pulse, snake_len, lives, game_over
  );

  // Controller side.
  modport slave (
    input  tick, game_active, cand_x, cand_y, cand_type, head_x, head_y, life_lost,
    output fruit_x, fruit_y, fruit_type, fruit_visible, eat_pulse, snake_len, lives, game_over
  );
endinterface

// File: rtl/fruit_controller.sv
// Fruit controller: samples one grid-snapped fruit from the generator stream, tracks its
// lifetime, detects the snake head eating it, applies the effect to length/lives and
// waits a cooldown before sampling the next fruit.
module fruit_controller #(
  parameter int unsigned GRID_LOG2  = 3,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned INIT_LEN   = 3,
  parameter int unsigned MIN_LEN    = 3,
  parameter int unsigned MAX_LEN    = 64,
  parameter int unsigned INIT_LIVES = 3,
  parameter int unsigned MAX_LIVES  = 7,
  parameter int unsigned LIFETIME   = 600,
  parameter int unsigned COOLDOWN   = 20,
  parameter int unsigned MAX_TRIES  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  fruit_controller_if.slave if_bus
);

  typedef enum logic [1:0] {StEmpty, StSample, StActive, StCooldown} state_e;

  localparam logic [9:0]  XMask     = ~10'((1 << GRID_LOG2) - 1);
  localparam logic [8:0]  YMask     = ~9'((1 << GRID_LOG2) - 1);
  localparam logic [10:0] HLim      = 11'(H_RES);
  localparam logic [9:0]  VLim      = 10'(V_RES);
  localparam logic [9:0]  FallX     = 10'(H_RES / 2);
  localparam logic [8:0]  FallY     = 9'(V_RES / 2);
  localparam logic [9:0]  LifeInit  = 10'(LIFETIME);
  localparam logic [7:0]  CoolInit  = 8'(COOLDOWN);
  localparam logic [7:0]  TryLast   = 8'(MAX_TRIES - 1);
  localparam logic [6:0]  LenInit   = 7'(INIT_LEN);
  localparam logic [6:0]  LenMin    = 7'(MIN_LEN);
  localparam logic [6:0]  LenMax    = 7'(MAX_LEN);
  localparam logic [2:0]  LivesInit = 3'(INIT_LIVES);
  localparam logic [2:0]  LivesMax  = 3'(MAX_LIVES);

  state_e     r_state, w_state_d;
  logic [7:0] r_try, w_try_d;
  logic [9:0] r_life, w_life_d;
  logic [7:0] r_cool, w_cool_d;
  logic [9:0] r_fruit_x, w_fruit_x_d;
  logic [8:0] r_fruit_y, w_fruit_y_d;
  logic [1:0] r_fruit_type, w_fruit_type_d;
  logic       r_visible, w_visible_d;
  logic       r_eat, w_eat_d;
  logic [6:0] r_len, w_len_d;
  logic [2:0] r_lives, w_lives_d, w_lives_inc;
  logic       r_game_over;
  logic       w_add_life;

  logic [9:0] w_sx, w_hx;
  logic [8:0] w_sy, w_hy;
  logic       w_accept, w_hit;

  assign w_sx = if_bus.cand_x & XMask;
  assign w_sy = if_bus.cand_y & YMask;
  assign w_hx = if_bus.head_x & XMask;
  assign w_hy = if_bus.head_y & YMask;

  // A candidate must carry a real type, lie on the playfield and not sit under the head.
  assign w_accept = (if_bus.cand_type != 2'b00) &&
                    ({1'b0, if_bus.cand_x} < HLim) &&
                    ({1'b0, if_bus.cand_y} < VLim) &&
                    !((w_sx == w_hx) && (w_sy == w_hy));

  assign w_hit = (w_hx == r_fruit_x) && (w_hy == r_fruit_y);

  // Next-state, counters, fruit latch and effect application.
  always_comb begin
    w_state_d      = r_state;
    w_try_d        = r_try;
    w_life_d       = r_life;
    w_cool_d       = r_cool;
    w_fruit_x_d    = r_fruit_x;
    w_fruit_y_d    = r_fruit_y;
    w_fruit_type_d = r_fruit_type;
    w_visible_d    = r_visible;
    w_eat_d        = 1'b0;
    w_len_d        = r_len;
    w_add_life     = 1'b0;

    if (!if_bus.game_active) begin
      // Leaving the game drops the fruit; any same-cycle hit is discarded.
      w_state_d   = StEmpty;
      w_visible_d = 1'b0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          w_state_d = StSample;
          w_try_d   = '0;
        end
        StSample: begin
          if (w_accept) begin
            w_fruit_x_d    = w_sx;
            w_fruit_y_d    = w_sy;
            w_fruit_type_d = if_bus.cand_type;
            w_visible_d    = 1'b1;
            w_life_d       = LifeInit;
            w_state_d      = StActive;
          end else if (r_try == TryLast) begin
            // Generator kept failing: place a grow fruit mid-screen, overlap not checked.
            w_fruit_x_d    = FallX;
            w_fruit_y_d    = FallY;
            w_fruit_type_d = 2'b01;
            w_visible_d    = 1'b1;
            w_life_d       = LifeInit;
            w_try_d        = '0;
            w_state_d      = StActive;
          end else begin
            w_try_d = r_try + 8'd1;
          end
        end
        StActive: begin
          if (if_bus.tick) begin
            if (w_hit) begin
              w_eat_d     = 1'b1;
              w_visible_d = 1'b0;
              w_cool_d    = CoolInit;
              w_state_d   = StCooldown;
              case (r_fruit_type)
                2'b01:   if (r_len < LenMax) w_len_d = r_len + 7'd1;
                2'b10:   if (r_len > LenMin) w_len_d = r_len - 7'd1;
                2'b11:   w_add_life = 1'b1;
                default: ;
              endcase
            end else if (r_life == 10'd1) begin
              w_visible_d = 1'b0;
              w_cool_d    = CoolInit;
              w_state_d   = StCooldown;
            end else begin
              w_life_d = r_life - 10'd1;
            end
          end
        end
        StCooldown: begin
          if (if_bus.tick) begin
            w_cool_d = r_cool - 8'd1;
            if (r_cool <= 8'd1) begin
              w_state_d = StSample;
              w_try_d   = '0;
            end
          end
        end
      endcase
    end

    // Extra life is added before the death is taken, so a full bar ends at MAX_LIVES-1.
    w_lives_inc = r_lives;
    if (w_add_life && (r_lives < LivesMax)) w_lives_inc = r_lives + 3'd1;
    w_lives_d = w_lives_inc;
    if (if_bus.life_lost && (w_lives_inc != 3'd0)) w_lives_d = w_lives_inc - 3'd1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StEmpty;
      r_try        <= '0;
      r_life       <= '0;
      r_cool       <= '0;
      r_fruit_x    <= '0;
      r_fruit_y    <= '0;
      r_fruit_type <= 2'b00;
      r_visible    <= 1'b0;
      r_eat        <= 1'b0;
      r_len        <= LenInit;
      r_lives      <= LivesInit;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_try        <= w_try_d;
      r_life       <= w_life_d;
      r_cool       <= w_cool_d;
      r_fruit_x    <= w_fruit_x_d;
      r_fruit_y    <= w_fruit_y_d;
      r_fruit_type <= w_fruit_type_d;
      r_visible    <= w_visible_d;
      r_eat        <= w_eat_d;
      r_len        <= w_len_d;
      r_lives      <= w_lives_d;
      r_game_over  <= (r_lives == 3'd0);
    end
  end

  assign if_bus.fruit_x       = r_fruit_x;
  assign if_bus.fruit_y       = r_fruit_y;
  assign if_bus.fruit_type    = r_fruit_type;
  assign if_bus.fruit_visible = r_visible;
  assign if_bus.eat_pulse     = r_eat;
  assign if_bus.snake_len     = r_len;
  assign if_bus.lives         = r_lives;
  assign if_bus.game_over     = r_game_over;

endmodule

// File: doc/fruit_controller.md
Name: fruit_controller

Overview:
- Sits directly downstream of the fruit generator and consumes its free-running candidate stream (x, y, type).
- Accepts one valid candidate and snaps it to the game grid. Holds it as the single on-screen fruit.
- Detects the snake head landing on it, applies the fruit's effect to snake length and lives, then requests a new fruit after a cooldown.
- Feeds the renderer (fruit position and visibility) and the snake engine (length and lives).

Parameters:
- GRID_LOG2, 3, cell size is 2^GRID_LOG2 pixels; positions snap by clearing the low GRID_LOG2 bits.
- H_RES, 640, horizontal playfield width in pixels.
- V_RES, 480, vertical playfield height in pixels.
- INIT_LEN, 3, snake length after reset.
- MIN_LEN, 3, lower saturation bound for length.
- MAX_LEN, 64, upper saturation bound for length (at most 127).
- INIT_LIVES, 3, lives after reset.
- MAX_LIVES, 7, upper saturation bound for lives.
- LIFETIME, 600, ticks a fruit stays visible before it expires (1..1023).
- COOLDOWN, 20, ticks with no fruit between consume/expire and the next sample (1..255).
- MAX_TRIES, 16, sample cycles allowed before the fallback fruit is used.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle game-step pulse.
- game_active  in  1  high while the game runs.
- cand_x  in  10  generator candidate x; may change every cycle.
- cand_y  in  9  generator candidate y.
- cand_type  in  2  generator candidate type: 00 none, 01 grow, 10 shrink, 11 extra life.
- head_x  in  10  snake head x in pixels.
- head_y  in  9  snake head y in pixels.
- life_lost  in  1  one-cycle pulse from the snake engine on collision death.
- fruit_x  out  10  latched, snapped fruit x.
- fruit_y  out  9  latched, snapped fruit y.
- fruit_type  out  2  latched fruit type.
- fruit_visible  out  1  fruit is on screen.
- eat_pulse  out  1  one-cycle pulse when the fruit is consumed.
- snake_len  out  7  current snake length.
- lives  out  3  current lives.
- game_over  out  1  registered; equals (lives == 0).

Behaviour:
- All outputs are registered. Reset is synchronous and active-high and takes priority over every other input.
- Reset values:
  - state EMPTY; fruit_x = 0, fruit_y = 0, fruit_type = 00.
  - fruit_visible = 0, eat_pulse = 0, game_over = 0.
  - snake_len = INIT_LEN, lives = INIT_LIVES; all internal counters = 0.
- FSM states are EMPTY, SAMPLE, ACTIVE and COOLDOWN.
- EMPTY: if game_active, go to SAMPLE next cycle with try counter = 0.
- SAMPLE: evaluate the candidate every clk, independent of tick.
  - snap: sx = cand_x with low GRID_LOG2 bits cleared; sy = cand_y with the same bits cleared.
  - accept when all hold: cand_type != 00, cand_x < H_RES, cand_y < V_RES, and (sx, sy) != snapped head.
  - on accept: latch sx, sy, cand_type; fruit_visible = 1 on the next cycle; life counter = LIFETIME; go to ACTIVE.
  - on reject: try counter +1. When a reject occurs with try counter == MAX_TRIES-1, latch the fallback fruit (H_RES/2, V_RES/2, 01) instead and go to ACTIVE. The fallback skips the head-overlap check.
- ACTIVE: evaluated only on tick.
  - hit = snapped head == (fruit_x, fruit_y).
  - hit: eat_pulse = 1 for exactly one cycle; apply the effect; fruit_visible = 0; cooldown counter = COOLDOWN; go to COOLDOWN.
  - else if life counter == 1: expire with no effect and no eat_pulse; fruit_visible = 0; go to COOLDOWN.
  - else: life counter -1.
  - hit has priority over expiry on the same tick.
- COOLDOWN: decrement on each tick. On the tick where the counter reaches 0, go to SAMPLE with try counter = 0.
- Effects (saturating; no wrap):
  - 01: snake_len +1, capped at MAX_LEN.
  - 10: snake_len -1, floored at MIN_LEN.
  - 11: lives +1, capped at MAX_LIVES.
- life_lost: lives -1, floored at 0. It can arrive in any state, including while game_active is low.
- Simultaneous extra-life eat and life_lost in the same cycle: net lives unchanged. If lives == MAX_LIVES, the result is MAX_LIVES-1.
- game_active low in any state:
  - next cycle: state EMPTY, fruit_visible = 0, eat_pulse = 0.
  - snake_len and lives are held.
  - a hit on the same cycle is discarded.
- game_over = (lives == 0), updated one cycle after lives changes. The block does not itself stop the game.
- Changes to cand_* while in ACTIVE or COOLDOWN have no effect.

Test Plan:
1. Reset then game_active = 1, cand = (100, 50, 10) → accepted on the first SAMPLE cycle; fruit_x = 96, fruit_y = 48, fruit_type = 10, fruit_visible = 1 two cycles after game_active rises.
2. Candidates (700, 10, 01), then (20, 20, 00), then (40, 40, 11) → the first two are rejected; fruit = (40, 40, 11); then head (43, 45) on a tick → eat_pulse for one cycle, lives 3→4, fruit_visible = 0.
3. Grow fruit with snake_len = 64 → eaten, snake_len stays 64. Shrink fruit with snake_len = 3 → stays 3.
4. LIFETIME = 4 with the head never on the fruit → fruit_visible falls on the 4th tick, no eat_pulse; after COOLDOWN = 20 ticks the block re-enters SAMPLE.
5. Only cand_type = 00 presented for 16 cycles → fallback fruit (320, 240, 01) is visible.
6. lives = 1, then life_lost → lives = 0 and game_over = 1 one cycle later. Extra-life eat and life_lost on the same cycle with lives = 2 → lives stays 2. Reset asserted while ACTIVE → every reset value is restored on the next clk.
